// File: rtl/exec_mem_datapath_pkg.sv
// Shared constants for the rv32i execute/memory datapath: widths, memory
// geometry, ALU operation codes and load func3 codes.
package exec_mem_datapath_pkg;

    localparam int DATA_WIDTH = 32;
    localparam int MEM_DEPTH  = 1024;
    localparam int ADDR_W     = 12;
    localparam int LANES      = DATA_WIDTH / 8;

    // ALU operation encodings
    localparam logic [3:0] ALU_ADD  = 4'b0000;
    localparam logic [3:0] ALU_SUB  = 4'b0001;
    localparam logic [3:0] ALU_AND  = 4'b0010;
    localparam logic [3:0] ALU_OR   = 4'b0011;
    localparam logic [3:0] ALU_XOR  = 4'b0100;
    localparam logic [3:0] ALU_SLL  = 4'b0101;
    localparam logic [3:0] ALU_SRL  = 4'b0110;
    localparam logic [3:0] ALU_SRA  = 4'b0111;
    localparam logic [3:0] ALU_SLT  = 4'b1000;
    localparam logic [3:0] ALU_SLTU = 4'b1001;

    // Load width/signedness encodings
    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;

    // True when the lane mask matches the access width implied by func3
    function automatic logic load_mask_legal(input logic [2:0] f3, input logic [3:0] mask);
        logic ok;
        ok = 1'b0;
        case (f3)
            F3_LB, F3_LBU: ok = (mask == 4'b0001) || (mask == 4'b0010) ||
                                (mask == 4'b0100) || (mask == 4'b1000);
            F3_LH, F3_LHU: ok = (mask == 4'b0011) || (mask == 4'b1100);
            F3_LW:         ok = (mask == 4'b1111);
            default:       ok = 1'b0;
        endcase
        return ok;
    endfunction

endpackage

// File: rtl/exec_mem_datapath_alu.sv
// Combinational ALU: arithmetic, logic, shifts and set-less-than.
module alu
    import exec_mem_datapath_pkg::*;
(
    input  logic [3:0]            alu_ctrl,
    input  logic [DATA_WIDTH-1:0] a,
    input  logic [DATA_WIDTH-1:0] b,
    output logic [DATA_WIDTH-1:0] result,
    output logic                  zero,
    output logic                  res_last_bit
);

    logic [4:0] w_shamt;
    assign w_shamt = b[4:0];

    // Select the operation result; unknown encodings yield zero
    always_comb begin
        result = {DATA_WIDTH{1'b0}};
        case (alu_ctrl)
            ALU_ADD:  result = a + b;
            ALU_SUB:  result = a - b;
            ALU_AND:  result = a & b;
            ALU_OR:   result = a | b;
            ALU_XOR:  result = a ^ b;
            ALU_SLL:  result = a << w_shamt;
            ALU_SRL:  result = a >> w_shamt;
            ALU_SRA:  result = $unsigned($signed(a) >>> w_shamt);
            ALU_SLT:  result = {{(DATA_WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
            ALU_SLTU: result = {{(DATA_WIDTH-1){1'b0}}, (a < b)};
            default:  result = {DATA_WIDTH{1'b0}};
        endcase
    end

    assign zero         = (result == {DATA_WIDTH{1'b0}});
    assign res_last_bit = result[0];

endmodule

// File: rtl/exec_mem_datapath_bram32.sv
// Word-organised data memory with per-byte write lanes, a combinational
// read port gated by the read enable, and an always-on debug read port.
module bram32
    import exec_mem_datapath_pkg::*;
#(
    parameter int DEPTH   = MEM_DEPTH,
    parameter int WORD_AW = $clog2(DEPTH)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  we,
    input  logic [WORD_AW-1:0]    waddr,
    input  logic [DATA_WIDTH-1:0] wdata,
    input  logic [LANES-1:0]      wbe,
    input  logic                  re,
    input  logic [WORD_AW-1:0]    raddr,
    output logic [DATA_WIDTH-1:0] rdata,
    input  logic [WORD_AW-1:0]    dbg_addr,
    output logic [DATA_WIDTH-1:0] dbg_data
);

    logic [DATA_WIDTH-1:0] r_mem [DEPTH];

    // Byte-lane writes on the clock edge; reset blocks writes but keeps contents
    always_ff @(posedge clk) begin
        if (we && !rst) begin
            for (int k = 0; k < LANES; k++) begin
                if (wbe[k]) begin
                    r_mem[waddr][8*k +: 8] <= wdata[8*k +: 8];
                end
            end
        end
    end

    // Read port: old contents until the write edge, forced to zero in reset
    always_comb begin
        if (rst || !re) begin
            rdata = {DATA_WIDTH{1'b0}};
        end else begin
            rdata = r_mem[raddr];
        end
    end

    assign dbg_data = r_mem[dbg_addr];

endmodule

// File: rtl/exec_mem_datapath_byte_reader.sv
// Load formatter: extracts the addressed byte/halfword/word and extends it.
module byte_reader
    import exec_mem_datapath_pkg::*;
(
    input  logic [2:0]            func3,
    input  logic [LANES-1:0]      mask,
    input  logic [DATA_WIDTH-1:0] data,
    output logic [DATA_WIDTH-1:0] wb_data,
    output logic                  valid
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;

    // Pick the byte lane named by the one-hot mask
    always_comb begin
        w_byte = 8'h00;
        case (mask)
            4'b0001: w_byte = data[7:0];
            4'b0010: w_byte = data[15:8];
            4'b0100: w_byte = data[23:16];
            4'b1000: w_byte = data[31:24];
            default: w_byte = 8'h00;
        endcase
    end

    // Pick the upper or lower halfword
    always_comb begin
        if (mask == 4'b1100) begin
            w_half = data[31:16];
        end else begin
            w_half = data[15:0];
        end
    end

    // Extend the selected lane; illegal func3/mask pairs give zero and invalid
    always_comb begin
        valid   = load_mask_legal(func3, mask);
        wb_data = {DATA_WIDTH{1'b0}};
        if (valid) begin
            case (func3)
                F3_LB:   wb_data = {{24{w_byte[7]}}, w_byte};
                F3_LBU:  wb_data = {24'h000000, w_byte};
                F3_LH:   wb_data = {{16{w_half[15]}}, w_half};
                F3_LHU:  wb_data = {16'h0000, w_half};
                F3_LW:   wb_data = data;
                default: wb_data = {DATA_WIDTH{1'b0}};
            endcase
        end else begin
            wb_data = {DATA_WIDTH{1'b0}};
        end
    end

endmodule

// File: rtl/exec_mem_datapath.sv
// Execute + data-memory datapath: ALU, byte-enabled data memory and load
// formatter. The ALU result addresses memory; an init port owns writes
// until init_done is raised.
module exec_mem_datapath
    import exec_mem_datapath_pkg::*;
#(
    parameter int DATA_WIDTH_P = DATA_WIDTH,
    parameter int DEPTH        = MEM_DEPTH
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [3:0]              alu_ctrl,
    input  logic                    alu_src,
    input  logic [DATA_WIDTH_P-1:0] src1,
    input  logic [DATA_WIDTH_P-1:0] src2,
    input  logic [DATA_WIDTH_P-1:0] sign_ext,
    input  logic [2:0]              func3,
    input  logic                    mem_read,
    input  logic                    mem_write,
    input  logic [3:0]              byte_enb,
    input  logic [DATA_WIDTH_P-1:0] wr_data,
    input  logic                    init_done,
    input  logic [ADDR_W-1:0]       init_addr,
    input  logic [DATA_WIDTH_P-1:0] init_dat,
    input  logic                    init_enb,
    input  logic [3:0]              init_byte_enb,
    input  logic [ADDR_W-1:0]       debug_addr,
    output logic [DATA_WIDTH_P-1:0] results,
    output logic                    zero,
    output logic                    res_last_bit,
    output logic [DATA_WIDTH_P-1:0] mem_data,
    output logic [DATA_WIDTH_P-1:0] wb_data,
    output logic                    valid,
    output logic [DATA_WIDTH_P-1:0] debug_data
);

    localparam int WORD_AW = $clog2(DEPTH);

    logic [DATA_WIDTH_P-1:0] w_opb;
    logic [DATA_WIDTH_P-1:0] w_results;
    logic [ADDR_W-1:0]       w_wr_addr;
    logic [DATA_WIDTH_P-1:0] w_wr_data;
    logic                    w_wr_en;
    logic [3:0]              w_wr_be;
    logic                    w_unused_bits;

    assign w_opb = alu_src ? sign_ext : src2;

    alu u_alu (
        .alu_ctrl     (alu_ctrl),
        .a            (src1),
        .b            (w_opb),
        .result       (w_results),
        .zero         (zero),
        .res_last_bit (res_last_bit)
    );

    assign results = w_results;

    // Write-port ownership: init port before init_done, datapath afterwards
    always_comb begin
        if (init_done) begin
            w_wr_addr = {w_results[ADDR_W-1:2], 2'b00};
            w_wr_data = wr_data;
            w_wr_en   = mem_write;
            w_wr_be   = byte_enb;
        end else begin
            w_wr_addr = init_addr;
            w_wr_data = init_dat;
            w_wr_en   = init_enb;
            w_wr_be   = init_byte_enb;
        end
    end

    // Byte offsets within a word play no part in word addressing
    assign w_unused_bits = ^{w_wr_addr[1:0], debug_addr[1:0]};

    bram32 #(
        .DEPTH   (DEPTH),
        .WORD_AW (WORD_AW)
    ) u_bram32 (
        .clk      (clk),
        .rst      (rst),
        .we       (w_wr_en),
        .waddr    (w_wr_addr[ADDR_W-1:2]),
        .wdata    (w_wr_data),
        .wbe      (w_wr_be),
        .re       (mem_read),
        .raddr    (w_results[ADDR_W-1:2]),
        .rdata    (mem_data),
        .dbg_addr (debug_addr[ADDR_W-1:2]),
        .dbg_data (debug_data)
    );

    byte_reader u_byte_reader (
        .func3   (func3),
        .mask    (byte_enb),
        .data    (mem_data),
        .wb_data (wb_data),
        .valid   (valid)
    );

endmodule

// File: tb/tb_exec_mem_datapath.sv
// Directed, table-driven bench for exec_mem_datapath.
module tb_exec_mem_datapath;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  alu_ctrl;
    logic        alu_src;
    logic [31:0] src1, src2, sign_ext;
    logic [2:0]  func3;
    logic        mem_read, mem_write;
    logic [3:0]  byte_enb;
    logic [31:0] wr_data;
    logic        init_done;
    logic [11:0] init_addr;
    logic [31:0] init_dat;
    logic        init_enb;
    logic [3:0]  init_byte_enb;
    logic [11:0] debug_addr;
    logic [31:0] results, mem_data, wb_data, debug_data;
    logic        zero, res_last_bit, valid;

    int n_checks = 0;
    int n_errors = 0;

    exec_mem_datapath dut (
        .clk(clk), .rst(rst), .alu_ctrl(alu_ctrl), .alu_src(alu_src),
        .src1(src1), .src2(src2), .sign_ext(sign_ext), .func3(func3),
        .mem_read(mem_read), .mem_write(mem_write), .byte_enb(byte_enb),
        .wr_data(wr_data), .init_done(init_done), .init_addr(init_addr),
        .init_dat(init_dat), .init_enb(init_enb), .init_byte_enb(init_byte_enb),
        .debug_addr(debug_addr), .results(results), .zero(zero),
        .res_last_bit(res_last_bit), .mem_data(mem_data), .wb_data(wb_data),
        .valid(valid), .debug_data(debug_data)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic [3:0]  op;
        logic        sel;
        logic [31:0] s1, s2, imm;
        logic [2:0]  f3;
        logic        rd;
        logic [3:0]  be;
        logic [31:0] e_res;
        logic [31:0] e_mem;
        logic [31:0] e_wb;
        logic        e_valid;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic add(input string name, input logic [3:0] op, input logic sel,
                       input logic [31:0] s1, input logic [31:0] s2, input logic [31:0] imm,
                       input logic [2:0] f3, input logic rd, input logic [3:0] be,
                       input logic [31:0] e_res, input logic [31:0] e_mem,
                       input logic [31:0] e_wb, input logic e_valid);
        vec_t v;
        v.name = name; v.op = op; v.sel = sel; v.s1 = s1; v.s2 = s2; v.imm = imm;
        v.f3 = f3; v.rd = rd; v.be = be; v.e_res = e_res; v.e_mem = e_mem;
        v.e_wb = e_wb; v.e_valid = e_valid;
        vecs.push_back(v);
    endtask

    task automatic init_write(input logic [11:0] a, input logic [31:0] d, input logic [3:0] be);
        init_done     = 1'b0;
        init_addr     = a;
        init_dat      = d;
        init_byte_enb = be;
        init_enb      = 1'b1;
        @(posedge clk); #1;
        init_enb      = 1'b0;
    endtask

    task automatic set_addr(input logic [31:0] a);
        alu_ctrl = 4'b0000; alu_src = 1'b0; src1 = a; src2 = 32'h0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; alu_ctrl = 4'b0000; alu_src = 1'b0; src1 = 32'h0; src2 = 32'h0;
        sign_ext = 32'h0; func3 = 3'b010; mem_read = 1'b1; mem_write = 1'b0;
        byte_enb = 4'b1111; wr_data = 32'h0; init_done = 1'b0; init_addr = 12'h0;
        init_dat = 32'h0; init_enb = 1'b0; init_byte_enb = 4'b0000; debug_addr = 12'h0;

        // Reset state: read path forced to zero
        #3;
        check("reset_mem_data", mem_data, 32'h0);
        check("reset_wb_data", wb_data, 32'h0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;

        // Init load through the init port
        init_write(12'h000, 32'h11223344, 4'b1111);
        init_write(12'h004, 32'h55667788, 4'b1111);
        init_write(12'h008, 32'h00000003, 4'b1111);
        init_write(12'h00C, 32'h00000000, 4'b1111);
        init_write(12'h010, 32'h000080FF, 4'b1111);
        debug_addr = 12'h008; #1;
        check("debug_word2", debug_data, 32'h00000003);
        debug_addr = 12'h00A; #1;
        check("debug_word2_offset", debug_data, 32'h00000003);
        debug_addr = 12'h004; #1;
        check("debug_word1", debug_data, 32'h55667788);

        // Store byte via datapath with read-during-write observation
        init_done = 1'b1;
        set_addr(32'h0000000C);
        mem_read = 1'b1; mem_write = 1'b1; byte_enb = 4'b0010; wr_data = 32'h0000AB00;
        #1;
        check("rdw_old_data", mem_data, 32'h00000000);
        @(posedge clk); #1;
        check("rdw_new_data", mem_data, 32'h0000AB00);
        mem_write = 1'b0;
        debug_addr = 12'h00C; #1;
        check("store_byte_debug", debug_data, 32'h0000AB00);

        // Empty lane mask writes nothing
        set_addr(32'h0); mem_write = 1'b1; byte_enb = 4'b0000; wr_data = 32'hFFFFFFFF;
        @(posedge clk); #1;
        mem_write = 1'b0;
        debug_addr = 12'h000; #1;
        check("zero_mask_write", debug_data, 32'h11223344);

        // Init port has no effect once init_done is set
        init_addr = 12'h000; init_dat = 32'h0; init_byte_enb = 4'b1111; init_enb = 1'b1;
        @(posedge clk); #1;
        init_enb = 1'b0;
        check("init_port_locked", debug_data, 32'h11223344);

        // Table: name, op, sel, s1, s2, imm, f3, rd, be, e_res, e_mem, e_wb, e_valid
        add("add_wrap", 4'b0000, 1'b0, 32'hFFFFFFFF, 32'h1, 32'h0, 3'b010, 1'b0, 4'b1111, 32'h0, 32'h0, 32'h0, 1'b1);
        add("slt",      4'b1000, 1'b0, 32'hFFFFFFFF, 32'h1, 32'h0, 3'b011, 1'b0, 4'b0000, 32'h1, 32'h0, 32'h0, 1'b0);
        add("sltu",     4'b1001, 1'b0, 32'hFFFFFFFF, 32'h1, 32'h0, 3'b011, 1'b0, 4'b0000, 32'h0, 32'h0, 32'h0, 1'b0);
        add("sra",      4'b0111, 1'b1, 32'h80000000, 32'h0, 32'h24, 3'b011, 1'b0, 4'b0000, 32'hF8000000, 32'h0, 32'h0, 1'b0);
        add("srl",      4'b0110, 1'b1, 32'h80000000, 32'h0, 32'h24, 3'b011, 1'b0, 4'b0000, 32'h08000000, 32'h0, 32'h0, 1'b0);
        add("sub",      4'b0001, 1'b0, 32'h5, 32'h7, 32'h0, 3'b011, 1'b0, 4'b0000, 32'hFFFFFFFE, 32'h0, 32'h0, 1'b0);
        add("and",      4'b0010, 1'b0, 32'hF0F0F0F0, 32'hFF00FF00, 32'h0, 3'b011, 1'b0, 4'b0000, 32'hF000F000, 32'h0, 32'h0, 1'b0);
        add("or",       4'b0011, 1'b0, 32'hF0F0F0F0, 32'hFF00FF00, 32'h0, 3'b011, 1'b0, 4'b0000, 32'hFFF0FFF0, 32'h0, 32'h0, 1'b0);
        add("xor",      4'b0100, 1'b0, 32'hF0F0F0F0, 32'hFF00FF00, 32'h0, 3'b011, 1'b0, 4'b0000, 32'h0FF00FF0, 32'h0, 32'h0, 1'b0);
        add("sll",      4'b0101, 1'b0, 32'h00000001, 32'h3F, 32'h0, 3'b011, 1'b0, 4'b0000, 32'h80000000, 32'h0, 32'h0, 1'b0);
        add("bad_op",   4'b1111, 1'b0, 32'h12345678, 32'h1, 32'h0, 3'b011, 1'b0, 4'b0000, 32'h0, 32'h0, 32'h0, 1'b0);
        add("lb_1000",  4'b0000, 1'b0, 32'h0, 32'h0, 32'h0, 3'b000, 1'b1, 4'b1000, 32'h0, 32'h11223344, 32'h00000011, 1'b1);
        add("lh_0011",  4'b0000, 1'b0, 32'h0, 32'h0, 32'h0, 3'b001, 1'b1, 4'b0011, 32'h0, 32'h11223344, 32'h00003344, 1'b1);
        add("lh_1100",  4'b0000, 1'b0, 32'h0, 32'h0, 32'h0, 3'b001, 1'b1, 4'b1100, 32'h0, 32'h11223344, 32'h00001122, 1'b1);
        add("lw",       4'b0000, 1'b0, 32'h0, 32'h0, 32'h0, 3'b010, 1'b1, 4'b1111, 32'h0, 32'h11223344, 32'h11223344, 1'b1);
        add("lw_badmsk",4'b0000, 1'b0, 32'h0, 32'h0, 32'h0, 3'b010, 1'b1, 4'b0011, 32'h0, 32'h11223344, 32'h0, 1'b0);
        add("lb_sext",  4'b0000, 1'b0, 32'h10, 32'h0, 32'h0, 3'b000, 1'b1, 4'b0001, 32'h10, 32'h000080FF, 32'hFFFFFFFF, 1'b1);
        add("lbu",      4'b0000, 1'b0, 32'h10, 32'h0, 32'h0, 3'b100, 1'b1, 4'b0001, 32'h10, 32'h000080FF, 32'h000000FF, 1'b1);
        add("lh_sext",  4'b0000, 1'b0, 32'h10, 32'h0, 32'h0, 3'b001, 1'b1, 4'b0011, 32'h10, 32'h000080FF, 32'hFFFF80FF, 1'b1);
        add("lhu",      4'b0000, 1'b0, 32'h10, 32'h0, 32'h0, 3'b101, 1'b1, 4'b0011, 32'h10, 32'h000080FF, 32'h000080FF, 1'b1);
        add("lb_2lanes",4'b0000, 1'b0, 32'h10, 32'h0, 32'h0, 3'b000, 1'b1, 4'b0011, 32'h10, 32'h000080FF, 32'h0, 1'b0);
        add("bad_f3",   4'b0000, 1'b0, 32'h10, 32'h0, 32'h0, 3'b011, 1'b1, 4'b1111, 32'h10, 32'h000080FF, 32'h0, 1'b0);
        add("addr_wrap",4'b0000, 1'b0, 32'h1004, 32'h0, 32'h0, 3'b010, 1'b1, 4'b1111, 32'h1004, 32'h55667788, 32'h55667788, 1'b1);
        add("addr_off2",4'b0000, 1'b0, 32'h2, 32'h0, 32'h0, 3'b010, 1'b1, 4'b1111, 32'h2, 32'h11223344, 32'h11223344, 1'b1);
        add("rd_off",   4'b0000, 1'b0, 32'h4, 32'h0, 32'h0, 3'b010, 1'b0, 4'b1111, 32'h4, 32'h0, 32'h0, 1'b1);

        mem_write = 1'b0;
        for (int i = 0; i < vecs.size(); i++) begin
            alu_ctrl = vecs[i].op; alu_src = vecs[i].sel; src1 = vecs[i].s1;
            src2 = vecs[i].s2; sign_ext = vecs[i].imm; func3 = vecs[i].f3;
            mem_read = vecs[i].rd; byte_enb = vecs[i].be;
            #2;
            check({vecs[i].name, "_res"},   results, vecs[i].e_res);
            check({vecs[i].name, "_zero"},  {31'h0, zero}, {31'h0, (vecs[i].e_res == 32'h0)});
            check({vecs[i].name, "_lsb"},   {31'h0, res_last_bit}, {31'h0, vecs[i].e_res[0]});
            check({vecs[i].name, "_mem"},   mem_data, vecs[i].e_mem);
            check({vecs[i].name, "_wb"},    wb_data, vecs[i].e_wb);
            check({vecs[i].name, "_valid"}, {31'h0, valid}, {31'h0, vecs[i].e_valid});
        end

        // Reset mid-run: read forced to zero, writes blocked, contents kept
        set_addr(32'h4); func3 = 3'b010; byte_enb = 4'b1111; mem_read = 1'b1;
        #1;
        check("pre_rst_mem", mem_data, 32'h55667788);
        rst = 1'b1; #1;
        check("rst_mem_zero", mem_data, 32'h0);
        check("rst_alu_kept", results, 32'h4);
        mem_write = 1'b1; wr_data = 32'hDEADBEEF;
        @(posedge clk); #1;
        mem_write = 1'b0;
        debug_addr = 12'h004; #1;
        check("rst_write_blocked", debug_data, 32'h55667788);
        rst = 1'b0; #1;
        check("post_rst_mem", mem_data, 32'h55667788);
        debug_addr = 12'h000; #1;
        check("post_rst_word0", debug_data, 32'h11223344);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
